// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and access sequencer for the
// shared data memory wrapper (RAM0 plus XALU/LEDS MMIO). Requester 0 is the CPU
// control unit, requester 1 is the debug/program loader. A granted access is
// latched, presented to the wrapper for one cycle (ACCESS), and reads take one
// extra cycle (WAIT) to cover the wrapper's registered read latency. Read data
// returns with a one-cycle rvalid pulse to the owning requester.
module mem_arbiter #(
  parameter int data_width = 8,
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0 (CPU control unit)
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  mmio0,
  input  logic [addr_width-1:0] addr0,
  input  logic [data_width-1:0] wdata0,
  // requester 1 (debug / program loader)
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  mmio1,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata1,
  // handshakes and shared read data
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [data_width-1:0] rdata,
  output logic                  busy,
  // memory wrapper port
  output logic [addr_width-1:0] m_addr,
  output logic [data_width-1:0] m_din,
  output logic                  m_write_en,
  output logic                  m_mmio,
  input  logic [data_width-1:0] m_dout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  // FSM state
  logic [1:0] state_reg;
  logic [1:0] state_next;

  // requester fields gathered into indexable form
  logic [1:0]            req_vec;
  logic [1:0]            we_vec;
  logic [1:0]            mmio_vec;
  logic [addr_width-1:0] addr_arr  [2];
  logic [data_width-1:0] wdata_arr [2];

  // arbitration
  logic winner;
  logic grant_take;
  logic owner_reg;
  logic last_owner_reg;

  // latched access fields; these also drive the wrapper port directly so the
  // MMIO decode in the wrapper never sees a glitch between accesses
  logic                  we_reg;
  logic                  mmio_reg;
  logic [addr_width-1:0] addr_reg;
  logic [data_width-1:0] wdata_reg;
  logic [data_width-1:0] rdata_reg;

  // per-requester handshake outputs
  logic [1:0] gnt_vec;
  logic [1:0] rvalid_vec;

  assign req_vec      = {req1, req0};
  assign we_vec       = {we1, we0};
  assign mmio_vec     = {mmio1, mmio0};
  assign addr_arr[0]  = addr0;
  assign addr_arr[1]  = addr1;
  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;

  // Round-robin pick: a lone requester always wins; on a tie the requester that
  // was not granted last wins, which makes continuous contention alternate.
  always_comb begin
    winner = 1'b0;
    if (req_vec == 2'b11) begin
      winner = ~last_owner_reg;
    end else if (req_vec[1]) begin
      winner = 1'b1;
    end
  end

  // Requests are only looked at in IDLE; ACCESS and WAIT ignore req entirely.
  assign grant_take = (state_reg == IDLE) && (req_vec != 2'b00);

  // Next-state decode: writes finish after ACCESS, reads go through WAIT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_take) state_next = ACCESS;
      ACCESS:  state_next = we_reg ? IDLE : WAIT;
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the winner's fields and remember the owner on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      we_reg         <= 1'b0;
      mmio_reg       <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else if (grant_take) begin
      owner_reg      <= winner;
      last_owner_reg <= winner;
      we_reg         <= we_vec[winner];
      mmio_reg       <= mmio_vec[winner];
      addr_reg       <= addr_arr[winner];
      wdata_reg      <= wdata_arr[winner];
    end
  end

  // Capture wrapper read data at the end of WAIT; hold it otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (state_reg == WAIT) begin
      rdata_reg <= m_dout;
    end
  end

  // Per-requester grant (combinational, ACCESS cycle) and read-valid pulse
  // (registered, the cycle after WAIT). Reset during WAIT kills the pulse.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic rvalid_reg;

      assign gnt_vec[gi] = (state_reg == ACCESS) && (owner_reg == 1'(gi));

      // Flag a completed read for this requester one cycle after WAIT.
      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= (state_reg == WAIT) && (owner_reg == 1'(gi));
        end
      end

      assign rvalid_vec[gi] = rvalid_reg;
    end
  endgenerate

  assign gnt0    = gnt_vec[0];
  assign gnt1    = gnt_vec[1];
  assign rvalid0 = rvalid_vec[0];
  assign rvalid1 = rvalid_vec[1];
  assign rdata   = rdata_reg;
  assign busy    = (state_reg != IDLE);

  // The write strobe exists only in an ACCESS cycle of a write; address, data
  // and MMIO select simply follow the latched fields.
  assign m_addr     = addr_reg;
  assign m_din      = wdata_reg;
  assign m_mmio     = mmio_reg;
  assign m_write_en = (state_reg == ACCESS) && we_reg;

endmodule
